// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and defaults for the DDR4 refresh timer.
// Refresh state encoding, default timing constants and the debt width.
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2,
    RFC   = 2'd3
  } ref_state_e;

  localparam int DEF_T_REFI       = 6240;
  localparam int DEF_T_RFC        = 280;
  localparam int DEF_MAX_POSTPONE = 8;

  // Debt is a 5-bit signed value covering -8..+8.
  localparam int DEBT_W = 5;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/ref_interval_cnt.sv
// ref_interval_cnt: modulo-MOD up counter with clear, load and a terminal-count pulse.
// Clear has priority over load, load over count. o_tc is high in the enabled
// cycle whose edge wraps the count from MOD-1 back to 0.
module ref_interval_cnt
  import ddr_pkg::*;
#(
  parameter int MOD = 16,
  localparam int W = cnt_width(MOD)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_cnt;

  // Count register: clear, then load, then wrap-around increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = i_en && (r_cnt == LAST);

endmodule

// File: rtl/ctrl_ref_timer.sv
// ctrl_ref_timer: DDR4 refresh interval timer with signed refresh-debt tracking.
// Raises ref_req when refreshes are owed, blocks for tRFC after each grant and
// flags ref_err when an interval elapses with the debt already saturated.
// Optional pull-in of refreshes on an idle bus is enabled by the macro
// CTRL_REF_PULLIN_EN; without it bus_idle is ignored and debt stays >= 0.
module ctrl_ref_timer
  import ddr_pkg::*;
#(
  parameter int T_REFI       = DEF_T_REFI,
  parameter int T_RFC        = DEF_T_RFC,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
  input  logic              CK_t,
  input  logic              reset,
  input  logic              init_done,
  input  logic              ref_ack,
  input  logic              bus_idle,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic              ref_busy,
  output logic [DEBT_W-1:0] ref_debt,
  output logic              ref_err
);

  localparam int REFI_W = cnt_width(T_REFI);
  localparam int RFC_W  = cnt_width(T_RFC);
  // Two guard bits so debt +/- 1 never overflows before saturation.
  localparam int SUM_W  = DEBT_W + 2;

  localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(MAX_POSTPONE);
`ifdef CTRL_REF_PULLIN_EN
  localparam logic signed [SUM_W-1:0] SUM_LO = -SUM_HI;
`else
  localparam logic signed [SUM_W-1:0] SUM_LO = '0;
`endif
  localparam logic signed [DEBT_W-1:0] DEBT_MAX  = SUM_HI[DEBT_W-1:0];
  localparam logic signed [DEBT_W-1:0] DEBT_ZERO = '0;

  ref_state_e              r_state;
  logic signed [DEBT_W-1:0] r_debt;
  logic                    r_req;
  logic                    r_busy;
  logic                    r_err;

  logic                    w_run;
  logic                    w_cnt_clr;
  logic                    w_tick;
  logic                    w_grant;
  logic                    w_rfc_done;
  logic                    w_go_req;
  logic signed [SUM_W-1:0] w_sum;
  logic [REFI_W-1:0]       w_refi_cnt;
  logic [RFC_W-1:0]        w_rfc_cnt;
  logic                    w_unused;

  // Clamp the widened debt sum into the legal debt range.
  function automatic logic signed [DEBT_W-1:0] sat_debt(input logic signed [SUM_W-1:0] v);
    if (v > SUM_HI) begin
      return SUM_HI[DEBT_W-1:0];
    end else if (v < SUM_LO) begin
      return SUM_LO[DEBT_W-1:0];
    end else begin
      return v[DEBT_W-1:0];
    end
  endfunction

  // Counters only advance once init is complete and we have left IDLE.
  assign w_run     = init_done && (r_state != IDLE);
  assign w_cnt_clr = !w_run;
  assign w_grant   = r_req && ref_ack;

  // Net debt change this cycle: +1 per interval tick, -1 per granted refresh.
  assign w_sum = {{(SUM_W-DEBT_W){r_debt[DEBT_W-1]}}, r_debt}
               + {{(SUM_W-1){1'b0}}, w_tick}
               - {{(SUM_W-1){1'b0}}, w_grant};

`ifdef CTRL_REF_PULLIN_EN
  // Owed refreshes always request; an idle bus may also pull one in early.
  assign w_go_req = (r_debt > DEBT_ZERO)
                 || ((r_debt > SUM_LO[DEBT_W-1:0]) && bus_idle);
  assign w_unused = ^{w_refi_cnt, w_rfc_cnt};
`else
  assign w_go_req = (r_debt > DEBT_ZERO);
  assign w_unused = ^{w_refi_cnt, w_rfc_cnt, bus_idle};
`endif

  ref_interval_cnt #(.MOD(T_REFI)) u_refi_cnt (
    .i_clk      (CK_t),
    .i_rst      (reset),
    .i_clr      (w_cnt_clr),
    .i_load     (1'b0),
    .i_load_val ({REFI_W{1'b0}}),
    .i_en       (w_run),
    .o_cnt      (w_refi_cnt),
    .o_tc       (w_tick)
  );

  // The tRFC window restarts from zero on the grant edge.
  ref_interval_cnt #(.MOD(T_RFC)) u_rfc_cnt (
    .i_clk      (CK_t),
    .i_rst      (reset),
    .i_clr      (w_cnt_clr),
    .i_load     (w_grant),
    .i_load_val ({RFC_W{1'b0}}),
    .i_en       (w_run && (r_state == RFC)),
    .o_cnt      (w_rfc_cnt),
    .o_tc       (w_rfc_done)
  );

  // Refresh sequencing FSM with registered request and busy outputs.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (!init_done) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= COUNT;
        end
        COUNT: begin
          if (w_go_req) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          if (ref_ack) begin
            r_state <= RFC;
            r_req   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RFC: begin
          if (w_rfc_done) begin
            r_state <= COUNT;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Debt account and sticky overflow flag; the flag survives init_done dropping.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_debt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_tick && (r_debt == DEBT_MAX)) begin
        r_err <= 1'b1;
      end
      if (!init_done) begin
        r_debt <= '0;
      end else begin
        r_debt <= sat_debt(w_sum);
      end
    end
  end

  assign ref_req    = r_req;
  assign ref_busy   = r_busy;
  assign ref_err    = r_err;
  assign ref_debt   = r_debt;
  assign ref_urgent = (r_debt == DEBT_MAX);

endmodule

// File: tb/tb_ctrl_ref_timer.sv
// tb_ctrl_ref_timer: directed and randomized bench for ctrl_ref_timer with
// an interval/debt reference model (T_REFI=16, T_RFC=4, MAX_POSTPONE=8).
module tb_ctrl_ref_timer;

  localparam int TR = 16;
  localparam int TF = 4;
  localparam int MP = 8;
`ifdef CTRL_REF_PULLIN_EN
  localparam bit PULLIN = 1'b1;
`else
  localparam bit PULLIN = 1'b0;
`endif

  logic       CK_t      = 1'b0;
  logic       reset     = 1'b1;
  logic       init_done = 1'b0;
  logic       ref_ack   = 1'b0;
  logic       bus_idle  = 1'b0;
  logic       ref_req;
  logic       ref_urgent;
  logic       ref_busy;
  logic [4:0] ref_debt;
  logic       ref_err;

  always #5 CK_t = ~CK_t;

  ctrl_ref_timer #(.T_REFI(TR), .T_RFC(TF), .MAX_POSTPONE(MP)) dut (
    .CK_t       (CK_t),
    .reset      (reset),
    .init_done  (init_done),
    .ref_ack    (ref_ack),
    .bus_idle   (bus_idle),
    .ref_req    (ref_req),
    .ref_urgent (ref_urgent),
    .ref_busy   (ref_busy),
    .ref_debt   (ref_debt),
    .ref_err    (ref_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: position in the refresh interval, owed refreshes,
  // outstanding request and remaining tRFC cycles.
  bit m_active;
  int m_pos;
  int m_debt;
  bit m_req;
  int m_busy_left;
  bit m_err;

  function automatic int clamp_debt(input int v);
    int lo;
    lo = PULLIN ? -MP : 0;
    if (v > MP) return MP;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_active    = 1'b0;
    m_pos       = 0;
    m_debt      = 0;
    m_req       = 1'b0;
    m_busy_left = 0;
    m_err       = 1'b0;
  endtask

  task automatic model_step();
    int tick;
    int grant;
    int nd;
    if (reset) begin
      model_reset();
    end else if (!init_done) begin
      m_active    = 1'b0;
      m_pos       = 0;
      m_debt      = 0;
      m_req       = 1'b0;
      m_busy_left = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_pos    = 0;
    end else begin
      tick  = (m_pos == TR - 1) ? 1 : 0;
      grant = (m_req && ref_ack) ? 1 : 0;
      m_pos = (m_pos + 1) % TR;
      if (tick == 1 && m_debt == MP) m_err = 1'b1;
      nd = clamp_debt(m_debt + tick - grant);
      if (m_req) begin
        if (ref_ack) begin
          m_req       = 1'b0;
          m_busy_left = TF;
        end
      end else if (m_busy_left > 0) begin
        m_busy_left = m_busy_left - 1;
      end else if (m_debt >= 1 ||
                   (PULLIN && m_debt <= 0 && m_debt > -MP && bus_idle)) begin
        m_req = 1'b1;
      end
      m_debt = nd;
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},    {31'b0, ref_req},    {31'b0, m_req});
    chk({tag, ".busy"},   {31'b0, ref_busy},   (m_busy_left > 0) ? 1 : 0);
    chk({tag, ".debt"},   32'($signed(ref_debt)), m_debt);
    chk({tag, ".urgent"}, {31'b0, ref_urgent}, (m_debt == MP) ? 1 : 0);
    chk({tag, ".err"},    {31'b0, ref_err},    {31'b0, m_err});
  endtask

  // One clock: drive inputs, let the edge happen, update model, check at negedge.
  task automatic step(input logic ack, input logic idle, input logic init, input string tag);
    ref_ack   = ack;
    bus_idle  = idle;
    init_done = init;
    @(posedge CK_t);
    model_step();
    @(negedge CK_t);
    check_all(tag);
  endtask

  // Assert reset between edges and check the outputs fall without a clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge CK_t);
    @(negedge CK_t);
    reset = 1'b0;
    check_all({tag, ".held"});
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge CK_t);
    @(negedge CK_t);
    check_all("reset");

    // Basic interval: tick at edge 16, request at 17, grant at 20.
    reset = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      step(1'b0, 1'b0, 1'b1, "ivl");
      if (c == 15) chk("pre_tick_req", {31'b0, ref_req}, 0);
    end
    chk("t16_debt", 32'($signed(ref_debt)), 1);
    step(1'b0, 1'b0, 1'b1, "t17");
    chk("t17_req", {31'b0, ref_req}, 1);
    step(1'b0, 1'b0, 1'b1, "t18");
    step(1'b0, 1'b0, 1'b1, "t19");
    step(1'b1, 1'b0, 1'b1, "t20");
    chk("t20_req", {31'b0, ref_req}, 0);
    chk("t20_busy", {31'b0, ref_busy}, 1);
    for (int c = 21; c <= 24; c++) step(1'b0, 1'b0, 1'b1, "rfc");
    chk("t24_busy", {31'b0, ref_busy}, 0);
    chk("t24_debt", 32'($signed(ref_debt)), 0);

    // No grants for nine intervals: saturation, urgency, sticky error.
    for (int c = 25; c <= 160; c++) begin
      step(1'b0, 1'b0, 1'b1, "post");
      if (c == 144) begin
        chk("t144_debt", 32'($signed(ref_debt)), 8);
        chk("t144_urgent", {31'b0, ref_urgent}, 1);
        chk("t144_err", {31'b0, ref_err}, 0);
      end
    end
    chk("t160_debt", 32'($signed(ref_debt)), 8);
    chk("t160_err", {31'b0, ref_err}, 1);

    // Grant, then drop init_done in the tRFC window.
    step(1'b1, 1'b0, 1'b1, "g161");
    chk("t161_debt", 32'($signed(ref_debt)), 7);
    step(1'b0, 1'b0, 1'b1, "r162");
    step(1'b0, 1'b0, 1'b0, "drop");
    chk("drop_busy", {31'b0, ref_busy}, 0);
    chk("drop_debt", 32'($signed(ref_debt)), 0);
    chk("drop_err", {31'b0, ref_err}, 1);
    step(1'b0, 1'b0, 1'b0, "idle");

    // Fresh start: grant on the tick edge with debt 3.
    async_reset("rst1");
    for (int c = 0; c <= 63; c++) step(1'b0, 1'b0, 1'b1, "acc");
    chk("t63_debt", 32'($signed(ref_debt)), 3);
    step(1'b1, 1'b0, 1'b1, "coinc");
    chk("coinc_debt", 32'($signed(ref_debt)), 3);
    chk("coinc_busy", {31'b0, ref_busy}, 1);
    step(1'b0, 1'b0, 1'b1, "rfc2");
    async_reset("rst2");

    // Idle bus and an always-granting arbiter.
    for (int c = 0; c < 120; c++) begin
      step(1'b1, 1'b1, 1'b1, "pull");
`ifdef CTRL_REF_PULLIN_EN
      if (c == 1) chk("pull_req_early", {31'b0, ref_req}, 1);
`else
      if (c == 15) chk("nopull_req_early", {31'b0, ref_req}, 0);
`endif
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rnd");
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 63) != 0), "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
